// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared command opcodes and read-side FSM state type
// Contents:
//   OP_WADDR / OP_WDATA / OP_RADDR / OP_RDATA - 2-bit command opcodes
//   state_t                                   - ST_IDLE (no word pending) / ST_HOLD (word on dout)
package spi_ram_pkg;
   localparam logic [1:0] OP_WADDR = 2'b00;
   localparam logic [1:0] OP_WDATA = 2'b01;
   localparam logic [1:0] OP_RADDR = 2'b10;
   localparam logic [1:0] OP_RDATA = 2'b11;
   typedef enum logic {ST_IDLE, ST_HOLD} state_t;
endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: MEM_DEPTH x DATA_W storage, one synchronous write port, one synchronous read port, no reset
// Ports:
//   clk     - rising-edge clock
//   we      - write enable; wr_data lands in mem[wr_addr] at the edge
//   wr_addr - write address
//   wr_data - write data
//   re      - read enable; rd_data captures mem[rd_addr] at the edge, otherwise holds
//   rd_addr - read address
//   rd_data - registered read data (old contents when reading the word being written)
module spi_ram_mem #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              re,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      if (re) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/spi_burst_ram.sv
// spi_burst_ram: command-driven RAM with write/read pointers and a one-deep held read output
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset (pointers, FSM, flags; memory keeps its contents)
//   rx_valid - din carries a command this cycle
//   din      - {opcode[1:0], payload[DATA_W-1:0]}
//   dout     - read data, valid while tx_valid is high
//   tx_valid - a read word is being presented
//   tx_ready - consumer takes dout this cycle
//   overrun  - one-cycle pulse when a read command is dropped
//   addr_err - one-cycle pulse when a pointer load is out of range
module spi_burst_ram
   import spi_ram_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256,
   parameter int AUTO_INC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [DATA_W+1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              overrun,
   output logic              addr_err
);
   state_t            state;
   logic [1:0]        op;
   logic [DATA_W-1:0] pay;
   logic [ADDR_W-1:0] ptr_arg, wr_ptr, rd_ptr;
   logic [DATA_W-1:0] rd_q;
   logic              addr_ok, rd_cmd, rd_take, wr_take, hold_next;

   function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] p);
      return (32'(p) == 32'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign op        = din[DATA_W+1:DATA_W];
   assign pay       = din[DATA_W-1:0];
   assign ptr_arg   = pay[ADDR_W-1:0];
   assign addr_ok   = 32'(ptr_arg) < 32'(MEM_DEPTH);
   assign rd_cmd    = rx_valid && op == OP_RDATA;
   // A read is taken when nothing is pending or the pending word leaves this same cycle.
   assign rd_take   = rd_cmd && (state == ST_IDLE || tx_ready);
   assign wr_take   = rx_valid && op == OP_WDATA;
   assign hold_next = rd_take || (state == ST_HOLD && !tx_ready);
   // The read register has no reset, so gate it with tx_valid to give dout=0 under reset.
   assign dout      = tx_valid ? rd_q : '0;

   spi_ram_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_mem (
      .clk    (clk),
      .we     (wr_take),
      .wr_addr(wr_ptr),
      .wr_data(pay),
      .re     (rd_take),
      .rd_addr(rd_ptr),
      .rd_data(rd_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tx_valid <= 1'b0;
         overrun  <= 1'b0;
         addr_err <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         state    <= hold_next ? ST_HOLD : ST_IDLE;
         tx_valid <= hold_next;
         overrun  <= rd_cmd && !rd_take;
         addr_err <= rx_valid && (op == OP_WADDR || op == OP_RADDR) && !addr_ok;
         if (rx_valid && op == OP_WADDR && addr_ok) wr_ptr <= ptr_arg;
         else if (wr_take && AUTO_INC != 0) wr_ptr <= nxt(wr_ptr);
         if (rx_valid && op == OP_RADDR && addr_ok) rd_ptr <= ptr_arg;
         else if (rd_take && AUTO_INC != 0) rd_ptr <= nxt(rd_ptr);
      end
   end
endmodule

// File: tb/tb_spi_burst_ram.sv
// tb_spi_burst_ram: two DUTs (depth 256 and 200) on shared stimulus, checked every cycle against a behavioural model
module tb_spi_burst_ram;
   localparam int DW = 8;
   logic          clk = 0, rst_n = 0, rx_valid = 0, tx_ready = 0, run = 0;
   logic [DW+1:0] din = '0;
   logic [1:0][DW-1:0] dq;
   logic [1:0]    tv, ov, ae;
   int            vectors = 0, errs = 0;

   spi_burst_ram #(.MEM_DEPTH(256)) u0 (.clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
      .dout(dq[0]), .tx_valid(tv[0]), .tx_ready(tx_ready), .overrun(ov[0]), .addr_err(ae[0]));
   spi_burst_ram #(.MEM_DEPTH(200)) u1 (.clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
      .dout(dq[1]), .tx_valid(tv[1]), .tx_ready(tx_ready), .overrun(ov[1]), .addr_err(ae[1]));

   always #5 clk = ~clk;

   // Behavioural model: memory array, two integer pointers, and a "pending word" per instance.
   logic [DW-1:0] m [2][256];
   logic [DW-1:0] word [2];
   int            wp [2] = '{0, 0}, rp [2] = '{0, 0};
   bit            hold [2] = '{0, 0}, eo [2] = '{0, 0}, ea [2] = '{0, 0};

   always @(posedge clk or negedge rst_n) begin
      int d, op, pay;
      bit rd, take;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            wp[k] = 0; rp[k] = 0; hold[k] = 0; eo[k] = 0; ea[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            d    = k ? 200 : 256;
            op   = int'(din[DW+1:DW]);
            pay  = int'(din[DW-1:0]);
            rd   = rx_valid && op == 3;
            take = rd && (!hold[k] || tx_ready);
            eo[k] = rd && !take;
            ea[k] = rx_valid && (op == 0 || op == 2) && pay >= d;
            if (rx_valid && op == 0 && pay < d) wp[k] = pay;
            if (rx_valid && op == 2 && pay < d) rp[k] = pay;
            if (take) begin
               word[k] = m[k][rp[k]];
               rp[k] = (rp[k] + 1) % d;
            end
            if (rx_valid && op == 1) begin
               m[k][wp[k]] = din[DW-1:0];
               wp[k] = (wp[k] + 1) % d;
            end
            hold[k] = take || (hold[k] && !tx_ready);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d tx_valid", k), 32'(tv[k]), 32'(hold[k]));
            chk($sformatf("u%0d overrun", k), 32'(ov[k]), 32'(eo[k]));
            chk($sformatf("u%0d addr_err", k), 32'(ae[k]), 32'(ea[k]));
            if (hold[k]) chk($sformatf("u%0d dout", k), 32'(dq[k]), 32'(word[k]));
         end
      end
   end

   task automatic step(input bit v, input logic [1:0] op, input logic [7:0] pay, input bit rdy);
      @(negedge clk);
      rx_valid = v;
      din      = {op, pay};
      tx_ready = rdy;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset tx_valid", 32'(tv[0]), 0);
      chk("reset dout", 32'(dq[0]), 0);
      rst_n = 1;
      run   = 1;
      // fill memory so every later read is of a known word
      step(1, 2'b00, 8'h00, 0);
      for (int i = 0; i < 256; i++) step(1, 2'b01, 8'($urandom), 0);
      // basic write then read, latency one
      step(1, 2'b00, 8'h10, 1);
      step(1, 2'b01, 8'hA5, 1);
      step(1, 2'b10, 8'h10, 1);
      step(1, 2'b11, 8'h00, 1);
      step(0, 2'b00, 8'h00, 1);
      chk("basic dout", 32'(dq[0]), 32'hA5);
      chk("basic tx_valid", 32'(tv[0]), 1);
      chk("basic dout u1", 32'(dq[1]), 32'hA5);
      step(0, 2'b00, 8'h00, 1);
      chk("basic release", 32'(tv[0]), 0);
      // wrap at the top of a 256-word memory, then burst read back
      step(1, 2'b00, 8'hFE, 1);
      step(1, 2'b01, 8'h11, 1);
      chk("u1 FE rejected", 32'(ae[1]), 1);
      chk("u0 FE accepted", 32'(ae[0]), 0);
      step(1, 2'b01, 8'h22, 1);
      step(1, 2'b01, 8'h33, 1);
      step(1, 2'b10, 8'hFE, 1);
      step(1, 2'b11, 8'h00, 1);
      step(1, 2'b11, 8'h00, 1);
      chk("wrap rd0", 32'(dq[0]), 32'h11);
      step(1, 2'b11, 8'h00, 1);
      chk("wrap rd1", 32'(dq[0]), 32'h22);
      step(0, 2'b00, 8'h00, 1);
      chk("wrap rd2", 32'(dq[0]), 32'h33);
      chk("burst valid", 32'(tv[0]), 1);
      step(0, 2'b00, 8'h00, 1);
      chk("burst end", 32'(tv[0]), 0);
      // overrun: second read while the first is still held
      step(1, 2'b00, 8'h11, 0);
      step(1, 2'b01, 8'h5C, 0);
      step(1, 2'b10, 8'h10, 0);
      step(1, 2'b11, 8'h00, 0);
      step(1, 2'b11, 8'h00, 0);
      chk("ovr held dout", 32'(dq[0]), 32'hA5);
      step(0, 2'b00, 8'h00, 0);
      chk("ovr pulse", 32'(ov[0]), 1);
      step(0, 2'b00, 8'h00, 0);
      chk("ovr once", 32'(ov[0]), 0);
      chk("ovr dout stable", 32'(dq[0]), 32'hA5);
      step(0, 2'b00, 8'h00, 1);
      step(1, 2'b11, 8'h00, 1);
      step(0, 2'b00, 8'h00, 1);
      chk("ovr ptr once", 32'(dq[0]), 32'h5C);
      // depth 200 range limit
      step(1, 2'b00, 8'hC8, 0);
      step(1, 2'b00, 8'hC7, 0);
      chk("C8 rejected", 32'(ae[1]), 1);
      step(1, 2'b01, 8'h77, 0);
      chk("C7 accepted", 32'(ae[1]), 0);
      step(1, 2'b10, 8'hC7, 1);
      step(1, 2'b11, 8'h00, 1);
      step(0, 2'b00, 8'h00, 1);
      chk("C7 readback", 32'(dq[1]), 32'h77);
      // reset during HOLD
      step(1, 2'b10, 8'h10, 0);
      step(1, 2'b11, 8'h00, 0);
      step(0, 2'b00, 8'h00, 0);
      chk("pre-reset hold", 32'(tv[0]), 1);
      #2 rst_n = 0;
      #1;
      chk("rst tx_valid", 32'(tv[0]), 0);
      chk("rst dout", 32'(dq[0]), 0);
      chk("rst tx_valid u1", 32'(tv[1]), 0);
      @(negedge clk);
      rst_n = 1;
      step(1, 2'b11, 8'h00, 1);
      step(0, 2'b00, 8'h00, 1);
      chk("mem kept", 32'(dq[0]), 32'h33);
      // random traffic with one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            @(negedge clk);
            #2 rst_n = 0;
            @(negedge clk);
            rst_n = 1;
         end
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 2) != 0);
      end
      step(0, 2'b00, 8'h00, 1);
      step(0, 2'b00, 8'h00, 1);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
